// File: rtl/l2_cache_pkg.sv
// Shared types and width helpers for the L2 cache.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITE_BACK, ALLOCATE, RESPOND, DONE
  } state_e;

  function automatic int off_bits(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int idx_bits(input int cache_size, input int block_size, input int num_ways);
    return $clog2(cache_size / block_size / num_ways);
  endfunction

  function automatic int tag_bits(input int addr_width, input int cache_size,
                                  input int block_size, input int num_ways);
    return addr_width - off_bits(block_size) - idx_bits(cache_size, block_size, num_ways);
  endfunction

endpackage

// File: rtl/l2_cache_victim_select.sv
// Replacement choice for one set: lowest invalid way, else round-robin pointer.
module l2_victim_select #(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    ptr_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic [WAY_W-1:0]    next_ptr_o
);

  logic found;

  // Scan for a free way; the pointer only moves when the set is full.
  always_comb begin
    found      = 1'b0;
    victim_o   = ptr_i;
    next_ptr_o = ptr_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found)
      next_ptr_o = (ptr_i == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_i + 1'b1;
  end

endmodule

// File: rtl/l2_cache.sv
// Set-associative write-back / write-allocate L2 cache, one request in flight.
// Optional feature macro: L2_PERF_CNT_EN adds hit/miss/write-back counters.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [ADDR_WIDTH-1:0]            l1_addr_i,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in_i,
  input  logic                             l1_read_i,
  input  logic                             l1_write_i,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out_o,
  output logic                             l1_ready_o,
  output logic                             l1_hit_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out_o,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in_i,
  output logic                             mem_read_o,
  output logic                             mem_write_o,
  input  logic                             mem_ready_i
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]                      hit_count_o,
  output logic [31:0]                      miss_count_o,
  output logic [31:0]                      writeback_count_o
`endif
);

  localparam int BLK_W    = BLOCK_SIZE * DATA_WIDTH;
  localparam int OFF_W    = off_bits(BLOCK_SIZE);
  localparam int IDX_W    = idx_bits(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int TAG_W    = tag_bits(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  // Line storage; contents are meaningless until the valid bit is set.
  logic [BLK_W-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q;

  state_e           state_q;
  logic             lk_q;      // first LOOKUP cycle gives the tag compare a full cycle
  logic             is_wr_q;
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic [WAY_W-1:0] vic_q;

  logic [BLK_W-1:0]      l1_data_out_q, mem_data_out_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  l1_ready_q, l1_hit_q, mem_read_q, mem_write_q;

  logic             hit, vic_dirty, set_full;
  logic [WAY_W-1:0] hit_way, victim, next_ptr;
  logic             unused_off;

  assign unused_off = ^l1_addr_i[OFF_W-1:0];

  // Tag compare across every valid way of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx_q][w] && tag_q[req_idx_q][w] == req_tag_q && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l2_victim_select #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_vsel (
    .valid_i    (valid_q[req_idx_q]),
    .ptr_i      (rr_q[req_idx_q]),
    .victim_o   (victim),
    .next_ptr_o (next_ptr)
  );

  assign set_full  = &valid_q[req_idx_q];
  assign vic_dirty = valid_q[req_idx_q][victim] && dirty_q[req_idx_q][victim];

  // Control FSM with registered outputs; also owns the tag/data/state arrays.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      lk_q           <= 1'b0;
      is_wr_q        <= 1'b0;
      req_tag_q      <= '0;
      req_idx_q      <= '0;
      wdata_q        <= '0;
      vic_q          <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      rr_q           <= '0;
      l1_data_out_q  <= '0;
      l1_ready_q     <= 1'b0;
      l1_hit_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else begin
      l1_ready_q <= 1'b0;
      case (state_q)
        IDLE: if (l1_read_i || l1_write_i) begin
          req_tag_q <= l1_addr_i[ADDR_WIDTH-1 -: TAG_W];
          req_idx_q <= l1_addr_i[OFF_W +: IDX_W];
          wdata_q   <= l1_data_in_i;
          is_wr_q   <= l1_write_i;
          lk_q      <= 1'b0;
          state_q   <= LOOKUP;
        end
        LOOKUP: if (!lk_q) begin
          lk_q <= 1'b1;
        end else begin
          lk_q <= 1'b0;
          if (hit) begin
            if (is_wr_q) begin
              data_q[req_idx_q][hit_way]  <= wdata_q;
              dirty_q[req_idx_q][hit_way] <= 1'b1;
            end else begin
              l1_data_out_q <= data_q[req_idx_q][hit_way];
            end
            l1_hit_q   <= 1'b1;
            l1_ready_q <= 1'b1;
            state_q    <= RESPOND;
          end else begin
            vic_q <= victim;
            if (set_full) rr_q[req_idx_q] <= next_ptr;
            if (vic_dirty) begin
              mem_write_q    <= 1'b1;
              mem_addr_q     <= {tag_q[req_idx_q][victim], req_idx_q, {OFF_W{1'b0}}};
              mem_data_out_q <= data_q[req_idx_q][victim];
              state_q        <= WRITE_BACK;
            end else if (is_wr_q) begin
              data_q[req_idx_q][victim]  <= wdata_q;
              tag_q[req_idx_q][victim]   <= req_tag_q;
              valid_q[req_idx_q][victim] <= 1'b1;
              dirty_q[req_idx_q][victim] <= 1'b1;
              l1_hit_q   <= 1'b0;
              l1_ready_q <= 1'b1;
              state_q    <= RESPOND;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
              state_q    <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: if (mem_ready_i) begin
          mem_write_q               <= 1'b0;
          valid_q[req_idx_q][vic_q] <= 1'b0;
          dirty_q[req_idx_q][vic_q] <= 1'b0;
          if (is_wr_q) begin
            // later assignments override the clear above: the way is reused at once
            data_q[req_idx_q][vic_q]  <= wdata_q;
            tag_q[req_idx_q][vic_q]   <= req_tag_q;
            valid_q[req_idx_q][vic_q] <= 1'b1;
            dirty_q[req_idx_q][vic_q] <= 1'b1;
            l1_hit_q   <= 1'b0;
            l1_ready_q <= 1'b1;
            state_q    <= RESPOND;
          end else begin
            mem_read_q <= 1'b1;
            mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            state_q    <= ALLOCATE;
          end
        end
        ALLOCATE: if (mem_ready_i) begin
          mem_read_q                <= 1'b0;
          data_q[req_idx_q][vic_q]  <= mem_data_in_i;
          tag_q[req_idx_q][vic_q]   <= req_tag_q;
          valid_q[req_idx_q][vic_q] <= 1'b1;
          dirty_q[req_idx_q][vic_q] <= 1'b0;
          l1_data_out_q <= mem_data_in_i;
          l1_hit_q      <= 1'b0;
          l1_ready_q    <= 1'b1;
          state_q       <= RESPOND;
        end
        RESPOND: state_q <= DONE;
        DONE: if (!l1_read_i && !l1_write_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l1_data_out_o  = l1_data_out_q;
  assign l1_ready_o     = l1_ready_q;
  assign l1_hit_o       = l1_hit_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_out_o = mem_data_out_q;
  assign mem_read_o     = mem_read_q;
  assign mem_write_o    = mem_write_q;

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;
  logic        lookup_fire, wb_done;

  assign lookup_fire = (state_q == LOOKUP) && lk_q;
  assign wb_done     = (state_q == WRITE_BACK) && mem_ready_i;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (lookup_fire && hit)  hit_count_q  <= hit_count_q + 32'd1;
      if (lookup_fire && !hit) miss_count_q <= miss_count_q + 32'd1;
      if (wb_done)             wb_count_q   <= wb_count_q + 32'd1;
    end
  end

  assign hit_count_o       = hit_count_q;
  assign miss_count_o      = miss_count_q;
  assign writeback_count_o = wb_count_q;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: expected L1 responses and memory transactions
// are queued as requests are issued and checked as the DUT produces them.
module tb_l2_cache;

  localparam int BW = 16 * 32;

  typedef struct { logic hit; logic chk; logic [BW-1:0] data; } l1_exp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [BW-1:0] data; } mem_tx_t;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [31:0]   l1_addr_i = '0;
  logic [BW-1:0] l1_data_in_i = '0;
  logic          l1_read_i = 1'b0, l1_write_i = 1'b0;
  logic [BW-1:0] l1_data_out_o;
  logic          l1_ready_o, l1_hit_o;
  logic [31:0]   mem_addr_o;
  logic [BW-1:0] mem_data_out_o;
  logic [BW-1:0] mem_data_in_i = '0;
  logic          mem_read_o, mem_write_o;
  logic          mem_ready_i = 1'b0;
`ifdef L2_PERF_CNT_EN
  logic [31:0]   hit_count, miss_count, writeback_count;
`endif

  int tests = 0, fails = 0;
  int mem_delay = 0;
  bit conc_seen = 1'b0;
  l1_exp_t exp_l1[$];
  mem_tx_t exp_mem[$];
  logic [BW-1:0] mimg [logic [31:0]];

  l2_cache dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .l1_addr_i(l1_addr_i), .l1_data_in_i(l1_data_in_i),
    .l1_read_i(l1_read_i), .l1_write_i(l1_write_i),
    .l1_data_out_o(l1_data_out_o), .l1_ready_o(l1_ready_o), .l1_hit_o(l1_hit_o),
    .mem_addr_o(mem_addr_o), .mem_data_out_o(mem_data_out_o),
    .mem_data_in_i(mem_data_in_i), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_ready_i(mem_ready_i)
`ifdef L2_PERF_CNT_EN
    , .hit_count_o(hit_count), .miss_count_o(miss_count),
    .writeback_count_o(writeback_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pat(input logic [31:0] a, input logic [7:0] s);
    logic [BW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {s, a[23:0]} + 32'(i);
    return r;
  endfunction

  function automatic logic [BW-1:0] img(input logic [31:0] a);
    if (mimg.exists(a)) return mimg[a];
    return pat(a, 8'hA5);
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    exp_mem.push_back('{wr: 1'b0, addr: a, data: '0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [BW-1:0] d);
    exp_mem.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  // Memory model: answers each held request after mem_delay idle cycles.
  initial begin
    int wcnt;
    mem_tx_t e;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        wcnt = 0;
      end else if (rst_n_i && (mem_read_o || mem_write_o)) begin
        if (mem_read_o && mem_write_o) conc_seen = 1'b1;
        if (wcnt >= mem_delay) begin
          mem_ready_i = 1'b1;
          tests++;
          if (exp_mem.size() == 0) begin
            fails++;
            $display("FAIL mem_unexpected: got wr=%0d addr=%h, required no memory traffic",
                     mem_write_o, mem_addr_o);
          end else begin
            e = exp_mem.pop_front();
            if (e.wr !== mem_write_o || e.addr !== mem_addr_o ||
                (e.wr && e.data !== mem_data_out_o)) begin
              fails++;
              $display("FAIL mem_tx: got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                       mem_write_o, mem_addr_o, mem_data_out_o, e.wr, e.addr, e.data);
            end
          end
          if (mem_write_o) mimg[mem_addr_o] = mem_data_out_o;
          else mem_data_in_i = img(mem_addr_o);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // L1 response monitor: every l1_ready pulse must match the oldest expectation.
  initial begin
    l1_exp_t e;
    forever begin
      @(negedge clk);
      if (l1_ready_o === 1'b1) begin
        tests++;
        if (exp_l1.size() == 0) begin
          fails++;
          $display("FAIL l1_unexpected: got l1_ready with hit=%0d, required no response", l1_hit_o);
        end else begin
          e = exp_l1.pop_front();
          if (l1_hit_o !== e.hit) begin
            fails++;
            $display("FAIL l1_hit: got %0d, required %0d", l1_hit_o, e.hit);
          end
          if (e.chk) begin
            tests++;
            if (l1_data_out_o !== e.data) begin
              fails++;
              $display("FAIL l1_data: got %h, required %h", l1_data_out_o, e.data);
            end
          end
        end
      end
    end
  end

  // Issue one L1 request, check completion latency and the single-cycle ready pulse.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [BW-1:0] d,
                        input bit exp_hit, input bit chk, input logic [BW-1:0] exp_d,
                        input int exp_lat, input int hold, input string name);
    int n;
    bit got;
    exp_l1.push_back('{hit: exp_hit, chk: chk, data: exp_d});
    l1_addr_i = a; l1_data_in_i = d; l1_write_i = wr; l1_read_i = ~wr;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (l1_ready_o === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: no l1_ready after %0d cycles, required %0d", name, n, exp_lat);
    end else if (n != exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests++;
      if (l1_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL %s_hold: got l1_ready=%b in held cycle %0d, required 0", name, l1_ready_o, h);
      end
    end
    l1_read_i = 1'b0; l1_write_i = 1'b0;
    @(negedge clk);
    tests++;
    if (l1_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse: got l1_ready=%b after response, required 0", name, l1_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if ({l1_ready_o, l1_hit_o, mem_read_o, mem_write_o} !== 4'b0 || l1_data_out_o !== '0 ||
        mem_addr_o !== '0 || mem_data_out_o !== '0) begin
      fails++;
      $display("FAIL %s: got rdy=%b hit=%b mrd=%b mwr=%b maddr=%h, required all outputs 0",
               name, l1_ready_o, l1_hit_o, mem_read_o, mem_write_o, mem_addr_o);
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read;
    exp_rd(32'h100);
    do_req(1'b0, 32'h100, '0, 1'b0, 1'b1, pat(32'h100, 8'hA5), 4, 0, "cold_read");
    do_req(1'b0, 32'h100, '0, 1'b1, 1'b1, pat(32'h100, 8'hA5), 3, 0, "read_hit");
  endtask

  task automatic test_write_alloc;
    do_req(1'b1, 32'h200, pat(32'h200, 8'hB0), 1'b0, 1'b0, '0, 3, 0, "write_miss");
    do_req(1'b0, 32'h200, '0, 1'b1, 1'b1, pat(32'h200, 8'hB0), 3, 0, "read_after_write");
  endtask

  task automatic test_evict_rr;
    // tag 1 is already resident and dirty, the rest fill ways 1..7
    do_req(1'b1, 32'h200, pat(32'h200, 8'hD0), 1'b1, 1'b0, '0, 3, 0, "fill_t1");
    for (int t = 2; t <= 8; t++)
      do_req(1'b1, 32'(t * 32'h200), pat(32'(t * 32'h200), 8'hD0), 1'b0, 1'b0, '0, 3, 0, "fill");
    exp_wr(32'h200, pat(32'h200, 8'hD0));
    do_req(1'b1, 32'h1200, pat(32'h1200, 8'hD0), 1'b0, 1'b0, '0, 4, 0, "evict_way0");
    exp_wr(32'h400, pat(32'h400, 8'hD0));
    do_req(1'b1, 32'h1400, pat(32'h1400, 8'hD0), 1'b0, 1'b0, '0, 4, 0, "evict_way1");
  endtask

  task automatic test_dirty_read_miss;
    mem_delay = 5;
    exp_wr(32'h600, pat(32'h600, 8'hD0));
    exp_rd(32'h1600);
    do_req(1'b0, 32'h1600, '0, 1'b0, 1'b1, pat(32'h1600, 8'hA5), 16, 0, "dirty_slow_miss");
    mem_delay = 0;
    // the line written back above must come back from memory intact
    exp_wr(32'h800, pat(32'h800, 8'hD0));
    exp_rd(32'h600);
    do_req(1'b0, 32'h600, '0, 1'b0, 1'b1, pat(32'h600, 8'hD0), 6, 0, "refetch_victim");
    do_req(1'b0, 32'h600, '0, 1'b1, 1'b1, pat(32'h600, 8'hD0), 3, 0, "refetch_hit");
  endtask

  task automatic test_back_to_back;
    do_req(1'b0, 32'h100, '0, 1'b1, 1'b1, pat(32'h100, 8'hA5), 3, 4, "held_read");
    do_req(1'b0, 32'h100, '0, 1'b1, 1'b1, pat(32'h100, 8'hA5), 3, 0, "after_hold");
  endtask

  task automatic test_reset_busy;
    int n;
    mem_delay = 1000;
    l1_addr_i = 32'h2010; l1_read_i = 1'b1; l1_write_i = 1'b0;
    n = 0;
    while (mem_read_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (mem_read_o !== 1'b1) begin
      fails++;
      $display("FAIL alloc_reach: got mem_read=%b after %0d cycles, required 1", mem_read_o, n);
    end
    @(negedge clk);
    rst_n_i = 1'b0; l1_read_i = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_in_allocate");
    rst_n_i = 1'b1; mem_delay = 0;
    @(negedge clk);
    exp_rd(32'h2010);
    do_req(1'b0, 32'h2010, '0, 1'b0, 1'b1, pat(32'h2010, 8'hA5), 4, 0, "post_reset_miss");
    // tag 9 was dirty in the cache only, so reset discarded it
    exp_rd(32'h1200);
    do_req(1'b0, 32'h1200, '0, 1'b0, 1'b1, pat(32'h1200, 8'hA5), 4, 0, "dirty_lost");
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_alloc();
    test_evict_rr();
    test_dirty_read_miss();
    test_back_to_back();
    test_reset_busy();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_l1.size() != 0 || exp_mem.size() != 0) begin
      fails++;
      $display("FAIL pending_expect: got %0d l1 and %0d mem outstanding, required 0",
               exp_l1.size(), exp_mem.size());
    end
    tests++;
    if (conc_seen) begin
      fails++;
      $display("FAIL mem_concurrent: got mem_read and mem_write high together, required never");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
